tc_array: RTL and testbench
===========================

TC_ARRAY -- requirements
Module: tc_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent timer channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 32, counter/preset width (8..32); register bits above CNT_W read 0.
REQ-003 SHALL have parameter ADDR_W, default 5, word-address width; ADDR_W >= clog2(NUM_CH)+2.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port addr  input  ADDR_W  word address; addr[ADDR_W-1:2] = channel, addr[1:0] = register.
REQ-007 SHALL have port we  input  1  write strobe for din at addr.
REQ-008 SHALL have port din  input  32  write data.
REQ-009 SHALL have port dout  output  32  read data at addr, combinational.
REQ-010 SHALL have port irq  output  NUM_CH  per-channel interrupt = pending & CTRL.IM.
REQ-011 SHALL have port irq_any  output  1  OR of irq.

Function
REQ-012 Per-channel registers SHALL be: reg 0 CTRL (RW), reg 1 PRESET (RW), reg 2 COUNT (RO; writes ignored), reg 3 STATUS (bit0 pending; write 1 clears, write 0 no effect).
REQ-013 CTRL bits SHALL be: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as one-shot), [3] IM, [7:4] PS prescale; bits [31:8] read 0.
REQ-014 Channel index >= NUM_CH: reads SHALL return 0, writes SHALL be ignored.
REQ-015 Each channel SHALL run FSM IDLE, LOAD, CNT, EXPIRE.
REQ-016 IDLE -> LOAD on the cycle after CTRL.EN reads 1; otherwise stays in IDLE with COUNT held.
REQ-017 LOAD SHALL copy PRESET to COUNT, clear the prescaler, and go to CNT in one cycle.
REQ-018 CNT SHALL generate one tick every PS+1 cycles; on a tick with COUNT > 1, COUNT decrements by 1.
REQ-019 On a tick with COUNT <= 1 (including PRESET = 0), COUNT SHALL become 0, pending SHALL set, and the FSM SHALL go to EXPIRE.
REQ-020 EXPIRE, MODE = one-shot: CTRL.EN SHALL clear and the FSM SHALL go to IDLE.
REQ-021 EXPIRE, MODE = auto-reload: the FSM SHALL go to LOAD.
REQ-022 Latency from the CTRL write (EN = 1, PS = 0, PRESET = N >= 1) to pending = 1 SHALL be N+2 cycles after the write edge.
REQ-023 Writing EN = 0 in any state SHALL force IDLE on the next edge; COUNT holds and pending is unaffected.
REQ-024 A PRESET write during CNT SHALL NOT change the running COUNT; it takes effect at the next LOAD.
REQ-025 Hardware set and W1C of pending in the same cycle: set SHALL win.
REQ-026 A CTRL write in the same cycle as the EXPIRE EN-clear: the written value SHALL win.
REQ-027 Channels SHALL be fully independent; one write affects only the addressed channel.

Reset
REQ-028 While reset = 0, all CTRL, PRESET, COUNT, pending and prescalers SHALL be 0, FSMs SHALL be IDLE, and irq / irq_any SHALL be 0, asynchronously.
REQ-029 Reset deassertion mid-count SHALL restart from IDLE with EN = 0; no spurious irq.

Verification
REQ-030 Ch0: PRESET = 5, CTRL = 0x9 (EN, one-shot, IM) -> irq[0] = 1 exactly 7 cycles after the CTRL write; CTRL reads 0x8; COUNT = 0; irq stays high until STATUS write 0x1.
REQ-031 Ch1: PRESET = 3, CTRL = 0xB (auto-reload) -> pending sets every 5 cycles; W1C in the same cycle as a set leaves pending = 1.
REQ-032 Ch0: PRESET = 4, CTRL = 0x29 (PS = 2) -> each decrement is 3 cycles apart; irq after 2+4*3 = 14 cycles.
REQ-033 Mid-count write CTRL = 0 at COUNT = 2 -> COUNT holds at 2, no irq; a PRESET write of 7 during CNT leaves COUNT unchanged until the next LOAD.
REQ-034 With NUM_CH = 2, write/read channel 3 -> dout = 0, no state change; IM = 0 with pending = 1 -> irq = 0, STATUS reads 1.
REQ-035 Assert reset = 0 asynchronously mid-CNT with irq high -> all outputs 0 before the next clk edge; after release, registers read 0.

Source files
------------

// File: rtl/tc_array.sv
// tc_array: NUM_CH independent down-counting timers behind a word-addressed
// register window (CTRL / PRESET / COUNT / STATUS per channel) with maskable irqs.
module tc_array #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  localparam int CH_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CNT    = 2'd2,
    ST_EXPIRE = 2'd3
  } state_t;

  logic [CH_W-1:0]        ch_s;
  logic [1:0]             reg_s;
  logic                   ch_ok_s;
  logic [NUM_CH-1:0][31:0] ctrl_rd_s;
  logic [NUM_CH-1:0][31:0] preset_rd_s;
  logic [NUM_CH-1:0][31:0] count_rd_s;
  logic [NUM_CH-1:0][31:0] status_rd_s;
  logic                   din_unused_s;

  assign ch_s         = addr[ADDR_W-1:2];
  assign reg_s        = addr[1:0];
  assign ch_ok_s      = (32'(ch_s) < 32'(NUM_CH));
  assign din_unused_s = ^din;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t           state_r;
    logic [7:0]       ctrl_r;
    logic [CNT_W-1:0] preset_r;
    logic [CNT_W-1:0] count_r;
    logic [3:0]       presc_r;
    logic             pending_r;
    logic             sel_s;
    logic             wr_ctrl_s;
    logic             wr_preset_s;
    logic             w1c_s;
    logic             stop_s;
    logic             go_s;
    logic             tick_s;
    logic             last_s;
    logic             expire_s;
    logic             reload_s;

    assign sel_s       = we && ch_ok_s && (32'(ch_s) == 32'(g));
    assign wr_ctrl_s   = sel_s && (reg_s == 2'd0);
    assign wr_preset_s = sel_s && (reg_s == 2'd1);
    assign w1c_s       = sel_s && (reg_s == 2'd3) && din[0];
    // A CTRL write with EN=0 stops the channel on its own write edge; enabling
    // only takes effect once EN is visible in the register.
    assign stop_s      = wr_ctrl_s ? ~din[0] : ~ctrl_r[0];
    assign go_s        = ctrl_r[0] & ~stop_s;
    // >= keeps the prescaler from wrapping if PS is lowered mid-count.
    assign tick_s      = (presc_r >= ctrl_r[7:4]);
    assign last_s      = (count_r <= CNT_W'(1));
    assign expire_s    = (state_r == ST_CNT) && !stop_s && tick_s && last_s;
    assign reload_s    = (ctrl_r[2:1] == 2'b01);

    // Software-visible registers: CTRL (with one-shot EN clear), PRESET, pending.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ctrl_r    <= 8'd0;
        preset_r  <= {CNT_W{1'b0}};
        pending_r <= 1'b0;
      end else begin
        if (wr_ctrl_s) begin
          ctrl_r <= din[7:0];
        end else if ((state_r == ST_EXPIRE) && !reload_s) begin
          ctrl_r <= {ctrl_r[7:1], 1'b0};
        end else begin
          ctrl_r <= ctrl_r;
        end

        if (wr_preset_s) begin
          preset_r <= din[CNT_W-1:0];
        end else begin
          preset_r <= preset_r;
        end

        if (expire_s) begin
          pending_r <= 1'b1;
        end else if (w1c_s) begin
          pending_r <= 1'b0;
        end else begin
          pending_r <= pending_r;
        end
      end
    end

    // Channel sequencer: IDLE -> LOAD -> CNT -> EXPIRE, owning COUNT and prescaler.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_r <= ST_IDLE;
        count_r <= {CNT_W{1'b0}};
        presc_r <= 4'd0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (go_s) begin
              state_r <= ST_LOAD;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_LOAD: begin
            if (stop_s) begin
              state_r <= ST_IDLE;
            end else begin
              count_r <= preset_r;
              presc_r <= 4'd0;
              state_r <= ST_CNT;
            end
          end
          ST_CNT: begin
            if (stop_s) begin
              state_r <= ST_IDLE;
            end else if (tick_s) begin
              presc_r <= 4'd0;
              if (last_s) begin
                count_r <= {CNT_W{1'b0}};
                state_r <= ST_EXPIRE;
              end else begin
                count_r <= count_r - CNT_W'(1);
              end
            end else begin
              presc_r <= presc_r + 4'd1;
            end
          end
          ST_EXPIRE: begin
            if (stop_s || !reload_s) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_LOAD;
            end
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end

    assign ctrl_rd_s[g]   = {24'd0, ctrl_r};
    assign preset_rd_s[g] = 32'(preset_r);
    assign count_rd_s[g]  = 32'(count_r);
    assign status_rd_s[g] = {31'd0, pending_r};
    assign irq[g]         = pending_r & ctrl_r[3];
  end

  // Read mux: OR of per-channel words, only the addressed in-range channel contributes.
  always_comb begin
    logic [31:0] word_s;
    dout = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      case (reg_s)
        2'd0:    word_s = ctrl_rd_s[i];
        2'd1:    word_s = preset_rd_s[i];
        2'd2:    word_s = count_rd_s[i];
        default: word_s = status_rd_s[i];
      endcase
      dout = dout | ((ch_ok_s && (32'(ch_s) == 32'(i))) ? word_s : 32'd0);
    end
  end

  assign irq_any = |irq;

endmodule

// File: tb/tb_tc_array.sv
// Randomised + directed bench for tc_array; a timestamp-based channel model
// predicts every readable register and the irq lines each cycle.
module tb_tc_array;

  localparam int NCH  = 2;
  localparam int CW   = 16;
  localparam int AW   = 5;
  localparam logic [31:0] CMASK = 32'h0000_FFFF;

  logic          clk;
  logic          reset;
  logic [AW-1:0] addr;
  logic          we;
  logic [31:0]   din;
  logic [31:0]   dout;
  logic [NCH-1:0] irq;
  logic          irq_any;

  int n_checks = 0;
  int n_errors = 0;
  int t = 0;

  // model state: register contents plus a schedule of absolute edge times
  logic [7:0]  m_ctrl   [NCH];
  logic [31:0] m_preset [NCH];
  logic [31:0] m_count  [NCH];
  bit          m_pend   [NCH];
  bit          m_active [NCH];
  int          m_tload  [NCH];
  int          m_texp   [NCH];
  int          m_n      [NCH];
  int          m_ps     [NCH];
  int          m_clear_at [NCH];

  tc_array #(.NUM_CH(NCH), .CNT_W(CW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .din(din),
    .dout(dout), .irq(irq), .irq_any(irq_any)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ra(input int ch, input int r);
    logic [2:0] c3;
    logic [1:0] r2;
    c3 = 3'(ch);
    r2 = 2'(r);
    return {c3, r2};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_ctrl[c] = 8'd0; m_preset[c] = 32'd0; m_count[c] = 32'd0;
      m_pend[c] = 1'b0; m_active[c] = 1'b0; m_tload[c] = 0; m_texp[c] = 0;
      m_n[c] = 0; m_ps[c] = 0; m_clear_at[c] = -1;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    int c;
    c = int'(a[4:2]);
    if (c >= NCH) return 32'd0;
    case (a[1:0])
      2'd0:    return {24'd0, m_ctrl[c]};
      2'd1:    return m_preset[c];
      2'd2:    return m_count[c];
      default: return {31'd0, m_pend[c]};
    endcase
  endfunction

  // Advance the model across one rising edge using the inputs presented before it.
  task automatic model_step();
    t = t + 1;
    if (!reset) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      bit sel, wc, wp, w1c, stop, setp;
      sel  = we && (int'(addr[4:2]) == c);
      wc   = sel && (addr[1:0] == 2'd0);
      wp   = sel && (addr[1:0] == 2'd1);
      w1c  = sel && (addr[1:0] == 2'd3) && din[0];
      stop = wc ? !din[0] : !m_ctrl[c][0];
      setp = 1'b0;
      if (m_active[c]) begin
        if (stop) begin
          m_active[c] = 1'b0;
        end else if (t == m_tload[c]) begin
          m_n[c]     = int'(m_preset[c]);
          m_count[c] = m_preset[c];
          m_ps[c]    = int'(m_ctrl[c][7:4]);
          m_texp[c]  = t + ((m_n[c] == 0) ? 1 : m_n[c]) * (m_ps[c] + 1);
        end else if (t > m_tload[c]) begin
          if (t == m_texp[c]) begin
            m_count[c] = 32'd0;
            setp = 1'b1;
            if (m_ctrl[c][2:1] == 2'b01) begin
              m_tload[c] = t + 2;
            end else begin
              m_active[c]   = 1'b0;
              m_clear_at[c] = t + 1;
            end
          end else if (m_n[c] != 0) begin
            m_count[c] = 32'(m_n[c] - (t - m_tload[c]) / (m_ps[c] + 1));
          end
        end
      end else if (m_clear_at[c] == t) begin
        m_ctrl[c][0] = 1'b0;
      end else if (m_ctrl[c][0] && !stop) begin
        m_active[c] = 1'b1;
        m_tload[c]  = t + 1;
      end
      if (wc) m_ctrl[c] = din[7:0];
      if (wp) m_preset[c] = din & CMASK;
      if (setp) m_pend[c] = 1'b1;
      else if (w1c) m_pend[c] = 1'b0;
    end
  endtask

  task automatic cyc(input logic w, input logic [4:0] a, input logic [31:0] d);
    we = w; addr = a; din = d;
    @(posedge clk);
    model_step();
    #1;
    we = 1'b0;
  endtask

  task automatic expect_rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
    addr = a;
    #1;
    check(nm, dout, exp);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, addr, 32'd0);
  endtask

  // Model-vs-DUT compare on every falling edge.
  initial begin
    logic [31:0] exp_irq;
    forever begin
      @(negedge clk);
      exp_irq = 32'd0;
      for (int c = 0; c < NCH; c++) exp_irq[c] = m_pend[c] & m_ctrl[c][3];
      check("irq", 32'(irq), exp_irq);
      check("irq_any", 32'(irq_any), {31'd0, |exp_irq});
      check("dout", dout, m_read(addr));
    end
  end

  initial begin
    int unsigned r;
    int c;
    logic [31:0] d;
    logic [7:0] cb;
    reset = 1'b0; we = 1'b0; addr = 5'd0; din = 32'd0;
    model_reset();
    idle(3);
    reset = 1'b1;
    idle(1);
    check("rst_irq", 32'(irq), 32'd0);
    expect_rd(ra(0, 0), 32'd0, "rst_ctrl");

    // one-shot, PRESET=5, IM: irq 7 edges after the CTRL write
    cyc(1'b1, ra(0, 1), 32'd5);
    cyc(1'b1, ra(0, 0), 32'h9);
    idle(6);
    check("irq0_before", 32'(irq[0]), 32'd0);
    idle(1);
    check("irq0_at7", 32'(irq[0]), 32'd1);
    idle(1);
    expect_rd(ra(0, 0), 32'h8, "ctrl_en_clr");
    expect_rd(ra(0, 2), 32'd0, "count_zero");
    idle(2);
    check("irq0_hold", 32'(irq[0]), 32'd1);
    cyc(1'b1, ra(0, 3), 32'h1);
    check("irq0_w1c", 32'(irq[0]), 32'd0);

    // auto-reload, PRESET=3: pending every 5, set beats W1C
    cyc(1'b1, ra(1, 1), 32'd3);
    cyc(1'b1, ra(1, 0), 32'hB);
    idle(4);
    expect_rd(ra(1, 3), 32'd0, "ar_before");
    idle(1);
    expect_rd(ra(1, 3), 32'd1, "ar_set5");
    cyc(1'b1, ra(1, 3), 32'h1);
    expect_rd(ra(1, 3), 32'd0, "ar_w1c");
    idle(3);
    expect_rd(ra(1, 3), 32'd0, "ar_pre10");
    cyc(1'b1, ra(1, 3), 32'h1);
    expect_rd(ra(1, 3), 32'd1, "set_wins");
    cyc(1'b1, ra(1, 0), 32'h0);
    cyc(1'b1, ra(1, 3), 32'h1);

    // prescale PS=2, PRESET=4: decrement every 3, irq at 14
    cyc(1'b1, ra(0, 1), 32'd4);
    cyc(1'b1, ra(0, 0), 32'h29);
    idle(2);
    expect_rd(ra(0, 2), 32'd4, "ps_cnt4");
    idle(3);
    expect_rd(ra(0, 2), 32'd3, "ps_cnt3");
    idle(3);
    expect_rd(ra(0, 2), 32'd2, "ps_cnt2");
    idle(5);
    check("ps_irq13", 32'(irq[0]), 32'd0);
    idle(1);
    check("ps_irq14", 32'(irq[0]), 32'd1);
    cyc(1'b1, ra(0, 3), 32'h1);

    // disable at COUNT=2 holds; PRESET write mid-count waits for next LOAD
    cyc(1'b1, ra(0, 1), 32'd5);
    cyc(1'b1, ra(0, 0), 32'h1);
    idle(5);
    expect_rd(ra(0, 2), 32'd2, "pre_dis");
    cyc(1'b1, ra(0, 0), 32'h0);
    idle(3);
    expect_rd(ra(0, 2), 32'd2, "dis_hold");
    expect_rd(ra(0, 3), 32'd0, "dis_nopend");
    cyc(1'b1, ra(0, 0), 32'h1);
    idle(2);
    cyc(1'b1, ra(0, 1), 32'd7);
    idle(1);
    expect_rd(ra(0, 2), 32'd3, "preset_late");
    idle(3);
    expect_rd(ra(0, 3), 32'd1, "im0_status");
    check("im0_irq", 32'(irq[0]), 32'd0);
    idle(1);
    cyc(1'b1, ra(0, 0), 32'h1);
    idle(2);
    expect_rd(ra(0, 2), 32'd7, "preset_loaded");

    // out-of-range channels
    cyc(1'b1, ra(3, 0), 32'h9);
    expect_rd(ra(3, 0), 32'd0, "ch3_rd");
    cyc(1'b1, ra(2, 1), 32'd5);
    expect_rd(ra(2, 1), 32'd0, "ch2_rd");

    // CTRL write on the one-shot EN-clear edge wins
    cyc(1'b1, ra(0, 0), 32'h0);
    cyc(1'b1, ra(0, 3), 32'h1);
    cyc(1'b1, ra(0, 1), 32'd2);
    cyc(1'b1, ra(0, 0), 32'h1);
    idle(4);
    cyc(1'b1, ra(0, 0), 32'h9);
    expect_rd(ra(0, 0), 32'h9, "ctrl_wins");
    idle(2);
    expect_rd(ra(0, 2), 32'd2, "rearm");

    // async reset mid-count with irq high
    cyc(1'b1, ra(1, 1), 32'd10);
    cyc(1'b1, ra(1, 0), 32'hB);
    idle(4);
    check("irq_pre_rst", 32'(irq_any), 32'd1);
    addr = ra(1, 2);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("arst_irq", 32'(irq), 32'd0);
    check("arst_any", 32'(irq_any), 32'd0);
    check("arst_dout", dout, 32'd0);
    idle(2);
    #2;
    reset = 1'b1;
    expect_rd(ra(1, 0), 32'd0, "post_ctrl");
    expect_rd(ra(0, 1), 32'd0, "post_preset");
    idle(8);
    check("no_spurious", 32'(irq), 32'd0);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(99);
      c = $urandom_range(NCH - 1);
      d = $urandom;
      if (r < 40) begin
        cyc(1'b0, 5'($urandom), d);
      end else if (r < 50) begin
        cyc(1'b1, ra(c, 3), d);
      end else if (r < 62) begin
        cyc(1'b1, ra(c, 1), ($urandom_range(3) == 0) ? d : 32'($urandom_range(6)));
      end else if (r < 80) begin
        if (!m_ctrl[c][0]) begin
          cb = {4'($urandom_range(3)), 1'($urandom_range(1)), 2'($urandom_range(3)),
                1'($urandom_range(4) != 0)};
          cyc(1'b1, ra(c, 0), {d[31:8], cb});
        end else if ($urandom_range(7) == 0) begin
          cyc(1'b1, ra(c, 0), {d[31:1], 1'b0});
        end else begin
          cyc(1'b0, ra(c, 2), d);
        end
      end else if (r < 85) begin
        cyc(1'b1, ra(c, 2), d);
      end else if (r < 90) begin
        cyc(1'b1, ra($urandom_range(7, 2), $urandom_range(3)), d);
      end else begin
        cyc(1'b0, ra(c, $urandom_range(3)), d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
